// File: rtl/otter_hazard_ctrl.sv
// OTTER hazard unit: FREEZE/flush/STALL control, shadow rd tracking, stall counter.
// Define OTTER_HAZARD_FWD_EN for EX/WB forwarding selects with load-use-only stalls.
module otter_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [4:0]             de_rs1_addr,
    input  logic [4:0]             de_rs2_addr,
    input  logic                   de_rs1_used,
    input  logic                   de_rs2_used,
    input  logic [4:0]             de_rd_addr,
    input  logic                   de_regWrite,
    input  logic                   de_memRead,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_write,
    output logic                   if_de_write,
    output logic                   de_ex_write,
    output logic                   ex_mem_write,
    output logic                   mem_wb_write,
    output logic                   if_de_flush,
    output logic                   de_ex_flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FREEZE} mode_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } shadow_t;

    // index 0 = EX, 1 = MEM, 2 = WB
    shadow_t sh [3];
    shadow_t de_ent;
    mode_t   mode;
    logic    hz1;
    logic    hz2;
    logic    hazard;

    assign de_ent = '{rd: de_rd_addr, wr: de_regWrite, ld: de_memRead};

`ifdef OTTER_HAZARD_FWD_EN
    assign hz1 = de_rs1_used && (de_rs1_addr != 5'd0)
              && sh[0].ld && (sh[0].rd == de_rs1_addr);
    assign hz2 = de_rs2_used && (de_rs2_addr != 5'd0)
              && sh[0].ld && (sh[0].rd == de_rs2_addr);
`else
    assign hz1 = de_rs1_used && (de_rs1_addr != 5'd0)
              && ((sh[0].wr && (sh[0].rd == de_rs1_addr))
               || (sh[1].wr && (sh[1].rd == de_rs1_addr)));
    assign hz2 = de_rs2_used && (de_rs2_addr != 5'd0)
              && ((sh[0].wr && (sh[0].rd == de_rs2_addr))
               || (sh[1].wr && (sh[1].rd == de_rs2_addr)));
`endif

    assign hazard = hz1 | hz2;

    // a taken branch outranks a hazard: the stalled instruction is discarded anyway
    always_comb begin
        mode = RUN;
        if (mem_busy)
            mode = FREEZE;
        else if (!ex_branch_taken && hazard)
            mode = STALL;
    end

    always_comb begin
        pc_write     = 1'b0;
        if_de_write  = 1'b0;
        de_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if_de_flush  = 1'b0;
        de_ex_flush  = 1'b0;
        if (RESET_N) begin
            unique case (mode)
                RUN: begin
                    pc_write     = 1'b1;
                    if_de_write  = 1'b1;
                    de_ex_write  = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                    if_de_flush  = ex_branch_taken;
                    de_ex_flush  = ex_branch_taken;
                end
                STALL: begin
                    de_ex_write  = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                    de_ex_flush  = 1'b1;
                end
                FREEZE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 3; i++)
                sh[i] <= '0;
            stall_cnt <= '0;
        end else begin
            if (de_ex_write)
                sh[0] <= de_ex_flush ? shadow_t'('0) : de_ent;
            if (ex_mem_write)
                sh[1] <= sh[0];
            if (mem_wb_write)
                sh[2] <= sh[1];
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

`ifdef OTTER_HAZARD_FWD_EN
    logic [1:0] fa_q;
    logic [1:0] fb_q;

    function automatic logic [1:0] src_sel(
        input logic [4:0] rs,
        input shadow_t    ex,
        input shadow_t    mem
    );
        if (rs == 5'd0)
            return 2'b00;
        if (ex.wr && (ex.rd == rs))
            return 2'b01;
        if (mem.wr && (mem.rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    // a bubble entering EX carries no forwarding
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fa_q <= 2'b00;
            fb_q <= 2'b00;
        end else if (de_ex_write) begin
            fa_q <= de_ex_flush ? 2'b00 : src_sel(de_rs1_addr, sh[0], sh[1]);
            fb_q <= de_ex_flush ? 2'b00 : src_sel(de_rs2_addr, sh[0], sh[1]);
        end
    end

    assign fwd_a_sel = fa_q;
    assign fwd_b_sel = fb_q;
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: directed pipeline scenarios plus randomized
// traffic against a per-instruction pipeline model (honours OTTER_HAZARD_FWD_EN).
module tb_otter_hazard_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic [4:0] de_rs1_addr;
    logic [4:0] de_rs2_addr;
    logic       de_rs1_used;
    logic       de_rs2_used;
    logic [4:0] de_rd_addr;
    logic       de_regWrite;
    logic       de_memRead;
    logic       ex_branch_taken;
    logic       mem_busy;

    logic        pc_write, if_de_write, de_ex_write, ex_mem_write, mem_wb_write;
    logic        if_de_flush, de_ex_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    logic        s_pc, s_ifde, s_deex, s_exmem, s_memwb, s_iffl, s_deexfl;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_cnt;

    logic [6:0] ctl;
    assign ctl = {pc_write, if_de_write, de_ex_write, ex_mem_write,
                  mem_wb_write, if_de_flush, de_ex_flush};

    localparam logic [6:0] C_RUN    = 7'b1111100;
    localparam logic [6:0] C_FLUSH  = 7'b1111111;
    localparam logic [6:0] C_STALL  = 7'b0011101;
    localparam logic [6:0] C_FREEZE = 7'b0000000;

    otter_hazard_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd_addr(de_rd_addr), .de_regWrite(de_regWrite),
        .de_memRead(de_memRead), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy),
        .pc_write(pc_write), .if_de_write(if_de_write),
        .de_ex_write(de_ex_write), .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write), .if_de_flush(if_de_flush),
        .de_ex_flush(de_ex_flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    otter_hazard_ctrl #(.STALL_CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET_N(RESET_N),
        .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rd_addr(de_rd_addr), .de_regWrite(de_regWrite),
        .de_memRead(de_memRead), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy),
        .pc_write(s_pc), .if_de_write(s_ifde),
        .de_ex_write(s_deex), .ex_mem_write(s_exmem),
        .mem_wb_write(s_memwb), .if_de_flush(s_iffl),
        .de_ex_flush(s_deexfl), .fwd_a_sel(s_fa),
        .fwd_b_sel(s_fb), .stall_cnt(s_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic de(input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] d, input logic w, input logic m);
        de_rs1_addr = r1;
        de_rs1_used = u1;
        de_rs2_addr = r2;
        de_rs2_used = u2;
        de_rd_addr  = d;
        de_regWrite = w;
        de_memRead  = m;
    endtask

    task automatic nop();
        de(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // Model: one record per instruction sitting in EX and MEM
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic [1:0] fa;
        logic [1:0] fb;
    } ent_t;

    ent_t m_ex;
    ent_t m_mem;
    int   m_cnt;

    function automatic logic src_hz(input logic used, input logic [4:0] rs);
        if (!used || rs == 5'd0)
            return 1'b0;
`ifdef OTTER_HAZARD_FWD_EN
        return m_ex.v && m_ex.ld && (m_ex.rd == rs);
`else
        return (m_ex.v && m_ex.wr && m_ex.rd == rs)
            || (m_mem.v && m_mem.wr && m_mem.rd == rs);
`endif
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        logic [1:0] s;
        s = 2'd0;
`ifdef OTTER_HAZARD_FWD_EN
        if (rs != 5'd0) begin
            if (m_ex.v && m_ex.wr && m_ex.rd == rs)
                s = 2'd1;
            else if (m_mem.v && m_mem.wr && m_mem.rd == rs)
                s = 2'd2;
        end
`endif
        return s;
    endfunction

    int base;

    initial begin
        RESET_N = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy = 1'b0;
        nop();
        #2;
        chk("rst_ctl", int'(ctl), int'(C_FREEZE));
        chk("rst_cnt", int'(stall_cnt), 0);
        chk("rst_fwd", int'({fwd_a_sel, fwd_b_sel}), 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        de(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("rel_run", int'(ctl), int'(C_RUN));
`ifdef OTTER_HAZARD_FWD_EN
        nxt();
        de(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        chk("fwd_nostall", int'(ctl), int'(C_RUN));
        nxt();
        nop();
        #1;
        chk("fwd_a01", int'(fwd_a_sel), 1);
        chk("fwd_b01", int'(fwd_b_sel), 1);
        nxt();
        de(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        nxt();
        de(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        chk("lu_stall", int'(ctl), int'(C_STALL));
        nxt();
        #1;
        chk("lu_resume", int'(ctl), int'(C_RUN));
        nxt();
        nop();
        #1;
        chk("lu_fwd_a10", int'(fwd_a_sel), 2);
        chk("lu_fwd_b00", int'(fwd_b_sel), 0);
        chk("lu_cnt", int'(stall_cnt), 1);
        base = 1;
`else
        nxt();
        de(5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        chk("nf_stall1", int'(ctl), int'(C_STALL));
        nxt();
        #1;
        chk("nf_stall2", int'(ctl), int'(C_STALL));
        nxt();
        #1;
        chk("nf_resume", int'(ctl), int'(C_RUN));
        nxt();
        nop();
        #1;
        chk("nf_fwd", int'({fwd_a_sel, fwd_b_sel}), 0);
        chk("nf_cnt", int'(stall_cnt), 2);
        base = 2;
`endif
        // taken branch over a pending load-use
        nxt();
        de(5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        nxt();
        de(5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_flush", int'(ctl), int'(C_FLUSH));
        chk("br_cnt", int'(stall_cnt), base);
        nxt();
        ex_branch_taken = 1'b0;
        nop();
        #1;
        chk("br_after", int'(ctl), int'(C_RUN));
        chk("br_cnt2", int'(stall_cnt), base);
        // freeze with a branch held in EX
        for (int i = 0; i < 3; i++) begin
            nxt();
            mem_busy = 1'b1;
            ex_branch_taken = 1'b1;
            #1;
            chk("frz_ctl", int'(ctl), int'(C_FREEZE));
        end
        nxt();
        mem_busy = 1'b0;
        #1;
        chk("frz_flush", int'(ctl), int'(C_FLUSH));
        chk("frz_cnt", int'(stall_cnt), base + 3);
        nxt();
        ex_branch_taken = 1'b0;
        #1;
        chk("frz_run", int'(ctl), int'(C_RUN));
        chk("sat_cnt", int'(s_cnt), 3);
        // asynchronous reset in the middle of a freeze
        nxt();
        mem_busy = 1'b1;
        nxt();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_ctl", int'(ctl), int'(C_FREEZE));
        chk("arst_cnt", int'(stall_cnt), 0);
        chk("arst_sat", int'(s_cnt), 0);
        chk("arst_fwd", int'({fwd_a_sel, fwd_b_sel}), 0);
        repeat (2) @(posedge CLK);
        #1;
        mem_busy = 1'b0;
        RESET_N = 1'b1;
        #1;
        chk("rel2_run", int'(ctl), int'(C_RUN));

        // randomized traffic
        nxt();
        RESET_N = 1'b0;
        nop();
        nxt();
        RESET_N = 1'b1;
        m_ex  = '0;
        m_mem = '0;
        m_cnt = 0;
        begin
            logic       hold_de;
            logic       hold_br;
            logic       hz;
            logic [6:0] exp_ctl;
            ent_t       nx;
            hold_de = 1'b0;
            hold_br = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (!hold_de) begin
                    de_rs1_addr = 5'($urandom_range(0, 3));
                    de_rs2_addr = 5'($urandom_range(0, 3));
                    de_rs1_used = 1'($urandom_range(0, 1));
                    de_rs2_used = 1'($urandom_range(0, 1));
                    de_rd_addr  = 5'($urandom_range(0, 3));
                    de_regWrite = 1'($urandom_range(0, 1));
                    de_memRead  = de_regWrite & ($urandom_range(0, 2) == 0);
                end
                if (!hold_br)
                    ex_branch_taken = ($urandom_range(0, 7) == 0);
                mem_busy = ($urandom_range(0, 6) == 0);
                #1;
                hz = src_hz(de_rs1_used, de_rs1_addr)
                   | src_hz(de_rs2_used, de_rs2_addr);
                if (mem_busy)
                    exp_ctl = C_FREEZE;
                else if (ex_branch_taken)
                    exp_ctl = C_FLUSH;
                else if (hz)
                    exp_ctl = C_STALL;
                else
                    exp_ctl = C_RUN;
                chk("rnd_ctl", int'(ctl), int'(exp_ctl));
                chk("rnd_cnt", int'(stall_cnt), (m_cnt > 65535) ? 65535 : m_cnt);
                chk("rnd_sat", int'(s_cnt), (m_cnt > 3) ? 3 : m_cnt);
`ifdef OTTER_HAZARD_FWD_EN
                if (m_ex.v) begin
                    chk("rnd_fwd_a", int'(fwd_a_sel), int'(m_ex.fa));
                    chk("rnd_fwd_b", int'(fwd_b_sel), int'(m_ex.fb));
                end
`else
                chk("rnd_fwd", int'({fwd_a_sel, fwd_b_sel}), 0);
`endif
                if (!exp_ctl[6])
                    m_cnt++;
                if (!mem_busy) begin
                    nx = '0;
                    if (!ex_branch_taken && !hz) begin
                        nx.v  = 1'b1;
                        nx.rd = de_rd_addr;
                        nx.wr = de_regWrite;
                        nx.ld = de_memRead;
                        nx.fa = exp_sel(de_rs1_addr);
                        nx.fb = exp_sel(de_rs2_addr);
                    end
                    m_mem = m_ex;
                    m_ex  = nx;
                end
                hold_de = !exp_ctl[5];
                hold_br = mem_busy && ex_branch_taken;
                nxt();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_hazard_ctrl.md
OTTER_HAZARD_CTRL -- requirements
Module: otter_hazard_ctrl

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, width of the saturating stall-cycle counter.
REQ-002 SHALL have port CLK  input  1  the single pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port de_rs1_addr / de_rs2_addr  input  5 each  source registers of the instruction in DE.
REQ-005 SHALL have port de_rs1_used / de_rs2_used  input  1 each  the DE instruction reads that source.
REQ-006 SHALL have port de_rd_addr  input  5  destination of the DE instruction.
REQ-007 SHALL have port de_regWrite  input  1  the DE instruction writes rd.
REQ-008 SHALL have port de_memRead  input  1  the DE instruction is a LOAD.
REQ-009 SHALL have port ex_branch_taken  input  1  a taken branch, JAL or JALR resolved in EX this cycle.
REQ-010 SHALL have port mem_busy  input  1  data memory not ready; the MEM stage must hold.
REQ-011 SHALL have ports pc_write, if_de_write, de_ex_write, ex_mem_write, mem_wb_write  output  1 each  stage-register enables.
REQ-012 SHALL have ports if_de_flush, de_ex_flush  output  1 each  load a NOP/bubble into that stage register.
REQ-013 SHALL have ports fwd_a_sel / fwd_b_sel  output  2 each  EX operand source: 00 register file, 01 ex_mem_aluRes, 10 WB data.
REQ-014 SHALL have port stall_cnt  output  STALL_CNT_W  count of cycles with pc_write low.

Function
REQ-015 SHALL keep shadow tracking registers {rd, regWrite, memRead} for EX, MEM and WB, shifting DE->EX->MEM->WB on every cycle in which the corresponding stage-register enable is high.
REQ-016 SHALL load an EX shadow entry with regWrite=0 and memRead=0 whenever de_ex_flush is high.
REQ-017 SHALL implement FSM states RUN, STALL and FREEZE; reset state RUN.
REQ-018 SHALL give the following priority for each cycle: FREEZE (mem_busy) > flush (ex_branch_taken) > STALL (hazard) > RUN.
REQ-019 In RUN, SHALL drive all write enables high and both flushes low.
REQ-020 SHALL enter FREEZE whenever mem_busy=1, drive all five write enables low and both flushes low, and return to RUN on the first cycle mem_busy=0.
REQ-021 On ex_branch_taken=1 with mem_busy=0, SHALL assert if_de_flush and de_ex_flush for exactly that cycle and keep pc_write high. Any pending hazard is discarded.
REQ-022 Branch taken during FREEZE SHALL be acted on in the first cycle after mem_busy falls, because EX is held stable.
REQ-023 SHALL define a hazard as: DE source used, its address nonzero, and equal to EX rd with EX memRead=1 (load-use).
REQ-024 In STALL, SHALL drive pc_write=0, if_de_write=0 and de_ex_flush=1, with the other enables high, and re-evaluate the hazard each cycle.
REQ-025 SHALL compute fwd_a_sel/fwd_b_sel at DE time and register them with de_ex_write so that they are valid while the instruction is in EX.
REQ-026 SHALL select 01 for a source when the EX shadow entry writes the matching nonzero rd. Otherwise it SHALL select 10 when the MEM shadow entry writes it. Otherwise it SHALL select 00.
REQ-027 SHALL never forward x0; the WB-to-DE overlap is resolved by the register file's write-before-read and is not tracked here.
REQ-028 SHALL increment stall_cnt in every cycle pc_write=0 and saturate at all-ones.

Reset
REQ-029 While RESET_N=0, SHALL drive: FSM=RUN, all shadow regWrite/memRead=0, fwd selects=00, stall_cnt=0, flushes=0 and all write enables=0.
REQ-030 Reset asserted mid-STALL or mid-FREEZE SHALL abandon that state immediately. The first cycle after release SHALL be RUN with all enables high.

Configuration
REQ-031 Macro OTTER_HAZARD_FWD_EN defined: forwarding per REQ-025..026, with stalls only for load-use.
REQ-032 Macro OTTER_HAZARD_FWD_EN undefined: fwd selects tied to 00. A hazard is any used nonzero source matching EX or MEM rd with regWrite=1, and it stalls until that entry clears.

Verification
REQ-033 Reset release, then addi x5 then add x6,x5,x5 -> no stall, fwd_a_sel=fwd_b_sel=01 in add's EX cycle (with FWD_EN).
REQ-034 lw x7 followed immediately by add x8,x7,x0 -> exactly one cycle pc_write=0; add's EX fwd_a_sel=10; stall_cnt=1.
REQ-035 ex_branch_taken=1 with a load-use pending in DE -> both flushes high for one cycle, no STALL, stall_cnt unchanged.
REQ-036 mem_busy=1 for 3 cycles concurrent with ex_branch_taken=1 -> all enables low for 3 cycles, flush on the 4th, stall_cnt +3.
REQ-037 Without FWD_EN, addi x5 then add x6,x5,x0 -> 2 stall cycles and fwd selects 00. With STALL_CNT_W=2 and 5 stalls, stall_cnt saturates at 3.
REQ-038 RESET_N low during FREEZE -> outputs at REQ-029 values asynchronously, and RUN on the first post-release cycle.
